rf_wr_arbiter: RTL and testbench
================================

# rf_wr_arbiter

Round-robin arbiter that shares the single write port of the 16x16 register file among N_REQ independent requesters. Each requester presents an address/data pair with a level request; the arbiter selects one winner per cycle, drives the register file write port from registered outputs, and returns a one-cycle grant pulse to the winner. The arbiter sits directly in front of the register file's write port (`in_w_en`, `in_w_add`, `in_w_data`); read ports are untouched.

## Interface
- N_REQ, 4, number of requesters (2..8)
- ADDR_W, 4, register address width
- DATA_W, 16, register data width
- in_clk  input  1  clock; all state updates on rising edge
- in_rst  input  1  reset, asynchronous, active-high
- in_req  input  N_REQ  per-requester write request (level)
- in_req_add  input  N_REQ*ADDR_W  packed addresses; requester i at bits [i*ADDR_W +: ADDR_W]
- in_req_data  input  N_REQ*DATA_W  packed data; requester i at bits [i*DATA_W +: DATA_W]
- in_hold  input  1  when high, no new grant is issued
- o_gnt  output  N_REQ  one-hot grant pulse, registered
- o_w_en  output  1  register file write enable, registered
- o_w_add  output  ADDR_W  register file write address, registered
- o_w_data  output  DATA_W  register file write data, registered
- o_wr_cnt  output  16  count of issued writes, wraps 0xFFFF -> 0x0000

## Operation
- Requester handshake:
  - Raise `in_req[i]` with a stable payload.
  - Hold the request and payload until the cycle in which `o_gnt[i]` = 1.
  - Deassert or change the payload on the clock edge that ends the grant cycle.
- Eligibility: `elig[i] = in_req[i] & ~o_gnt[i]`.
  - A requester under grant this cycle is masked, so a still-high request is never double-granted.
- Round-robin pointer `ptr` (log2 N_REQ bits, reset 0):
  - Search order is ptr, ptr+1, … wrapping modulo N_REQ.
  - The first eligible index wins.
- On each rising edge, when `in_hold` = 0 and a winner w exists:
  - `o_gnt` <= onehot(w), `o_w_en` <= 1
  - `o_w_add` <= payload address of w, `o_w_data` <= payload data of w
  - `ptr` <= (w+1) mod N_REQ
  - `o_wr_cnt` <= `o_wr_cnt` + 1 (wrapping)
- When there is no winner or `in_hold` = 1:
  - `o_gnt` <= 0, `o_w_en` <= 0.
  - `o_w_add`, `o_w_data`, `ptr` and `o_wr_cnt` hold their values.
- Addresses are not checked for conflicts: two requesters writing the same register are serialized in grant order, and the last write wins.
- `in_hold` only suppresses new grants. A grant already registered completes its cycle normally.

## Timing
- Reset (async assert, effective immediately):
  - `o_gnt` = 0, `o_w_en` = 0, `o_w_add` = 0, `o_w_data` = 0, `o_wr_cnt` = 0, `ptr` = 0.
  - A write in flight is dropped, with no register file write.
  - Reset release is synchronous to `in_clk` from the design's standpoint.
- Latency:
  - Request sampled in cycle t -> `o_gnt`/`o_w_en` high in cycle t+1.
  - Register file updated at the end of t+1; data readable from the register file in t+2.
- Throughput:
  - One write per cycle when different requesters alternate.
  - One write per 2 cycles for a single continuously requesting requester, because of the grant mask.
- `o_gnt` and `o_w_en` are exactly one cycle wide per winner and always coincide: `o_w_en` = |`o_gnt`.
- Simultaneous requests: exactly one grant per cycle. Worst-case wait for any requester is N_REQ cycles after eligibility when `in_hold` = 0.
- `in_hold` rising in cycle t: no grant in t+1. `in_hold` falling in cycle t: a grant is possible in t+1.
- `o_wr_cnt` increments on the same edge that raises `o_w_en`.

## Test plan
- Reset/idle:
  - Stimulus: assert `in_rst` mid-grant, release, no requests for 5 cycles.
  - Required: all outputs 0 and `o_wr_cnt` = 0 throughout.
- Single requester:
  - Stimulus: `in_req` = 0001, add 0x3, data 0xA5A5, deassert after the grant.
  - Required: `o_gnt` = 0001 and `o_w_en` = 1 one cycle after the request; `o_w_add` = 0x3, `o_w_data` = 0xA5A5; register 3 reads 0xA5A5 one cycle later; `o_wr_cnt` = 1.
- Round-robin fairness:
  - Stimulus: `in_req` = 1111 held continuously, each requester dropping its request after its grant.
  - Required: grants 0001, 0010, 0100, 1000 on four consecutive cycles; `o_wr_cnt` = 4.
- Back-to-back same requester:
  - Stimulus: requester 2 requests continuously, changing payload after each grant, with others idle.
  - Required: `o_gnt` = 0100 every other cycle and never two consecutive cycles.
- Hold:
  - Stimulus: `in_req` = 0011 with `in_hold` = 1 for 3 cycles, then 0.
  - Required: no `o_w_en` during the hold; first grant appears the cycle after the hold drops and goes to the index at `ptr`.
- Same-address conflict:
  - Stimulus: requesters 0 and 1 both target 0x7 with 0x1111 and 0x2222, `ptr` = 0.
  - Required: writes issue in order 0x1111 then 0x2222; register 7 ends at 0x2222.

Source files
------------

// File: rtl/rf_wr_arbiter_if.sv
// Write-request bus between the requesters and the register-file write arbiter.
// Requester-side signals carry the in_ prefix, arbiter results the o_ prefix.
interface rf_wr_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
);
    logic [N_REQ-1:0]        in_req;
    logic [N_REQ*ADDR_W-1:0] in_req_add;
    logic [N_REQ*DATA_W-1:0] in_req_data;
    logic                    in_hold;
    logic [N_REQ-1:0]        o_gnt;
    logic                    o_w_en;
    logic [ADDR_W-1:0]       o_w_add;
    logic [DATA_W-1:0]       o_w_data;
    logic [15:0]             o_wr_cnt;

    modport master (
        output in_req, in_req_add, in_req_data, in_hold,
        input  o_gnt, o_w_en, o_w_add, o_w_data, o_wr_cnt
    );

    modport slave (
        input  in_req, in_req_add, in_req_data, in_hold,
        output o_gnt, o_w_en, o_w_add, o_w_data, o_wr_cnt
    );
endinterface

// File: rtl/rf_wr_arbiter.sv
// Round-robin arbiter sharing the single register-file write port among
// N_REQ requesters. One registered grant per cycle; a requester under grant
// is masked so a level request held through its grant cycle is not re-granted.
module rf_wr_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) (
    input  logic            in_clk,
    input  logic            in_rst,
    rf_wr_arbiter_if.slave  bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]  gnt_q,    gnt_d;
    logic              w_en_q,   w_en_d;
    logic [ADDR_W-1:0] w_add_q,  w_add_d;
    logic [DATA_W-1:0] w_data_q, w_data_d;
    logic [15:0]       wr_cnt_q, wr_cnt_d;
    logic [PTR_W-1:0]  ptr_q,    ptr_d;

    logic [N_REQ-1:0]  elig;
    logic              found;
    logic [PTR_W-1:0]  win;

    // Winner search: first eligible index starting at ptr, wrapping.
    always_comb begin
        elig  = bus.in_req & ~gnt_q;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && elig[(int'(ptr_q) + k) % N_REQ]) begin
                found = 1'b1;
                win   = PTR_W'((int'(ptr_q) + k) % N_REQ);
            end
        end
    end

    // Next state: issue a grant unless held; payload, pointer and count hold otherwise.
    always_comb begin
        gnt_d    = '0;
        w_en_d   = 1'b0;
        w_add_d  = w_add_q;
        w_data_d = w_data_q;
        wr_cnt_d = wr_cnt_q;
        ptr_d    = ptr_q;
        if (!bus.in_hold && found) begin
            gnt_d    = N_REQ'(1) << win;
            w_en_d   = 1'b1;
            w_add_d  = bus.in_req_add[int'(win)*ADDR_W +: ADDR_W];
            w_data_d = bus.in_req_data[int'(win)*DATA_W +: DATA_W];
            wr_cnt_d = wr_cnt_q + 16'd1;
            if (int'(win) == N_REQ - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = win + PTR_W'(1);
            end
        end
    end

    // State registers; reset drops any write in flight.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            gnt_q    <= '0;
            w_en_q   <= 1'b0;
            w_add_q  <= '0;
            w_data_q <= '0;
            wr_cnt_q <= '0;
            ptr_q    <= '0;
        end else begin
            gnt_q    <= gnt_d;
            w_en_q   <= w_en_d;
            w_add_q  <= w_add_d;
            w_data_q <= w_data_d;
            wr_cnt_q <= wr_cnt_d;
            ptr_q    <= ptr_d;
        end
    end

    assign bus.o_gnt    = gnt_q;
    assign bus.o_w_en   = w_en_q;
    assign bus.o_w_add  = w_add_q;
    assign bus.o_w_data = w_data_q;
    assign bus.o_wr_cnt = wr_cnt_q;
endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed bench for rf_wr_arbiter: expected writes queued when requests are
// driven and matched by a write-port monitor; cycle-exact checks in the main flow.
module tb_rf_wr_arbiter;
    logic in_clk;
    logic in_rst;

    rf_wr_arbiter_if #(.N_REQ(4), .ADDR_W(4), .DATA_W(16)) bus ();

    rf_wr_arbiter #(.N_REQ(4), .ADDR_W(4), .DATA_W(16)) dut (
        .in_clk (in_clk),
        .in_rst (in_rst),
        .bus    (bus)
    );

    typedef struct {
        logic [3:0]  gnt;
        logic [3:0]  add;
        logic [15:0] data;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] rf_mem [16];

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    // Register file model fed by the arbiter write port.
    always @(posedge in_clk) begin
        if (bus.o_w_en) rf_mem[bus.o_w_add] <= bus.o_w_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge in_clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] a, input logic [15:0] d);
        bus.in_req_add[i*4 +: 4]   = a;
        bus.in_req_data[i*4*4 +: 16] = d;
        bus.in_req[i]              = 1'b1;
    endtask

    task automatic push(input logic [3:0] g, input logic [3:0] a, input logic [15:0] d);
        exp_t e;
        e.gnt  = g;
        e.add  = a;
        e.data = d;
        sb.push_back(e);
    endtask

    // Write-port monitor: enable tracks the grant, each write matches the queue head.
    always @(negedge in_clk) begin
        chk("w_en_eq_or_gnt", {31'd0, bus.o_w_en}, {31'd0, |bus.o_gnt});
        if (bus.o_w_en) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", {12'd0, bus.o_w_add, bus.o_w_data}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_gnt",  {28'd0, bus.o_gnt},    {28'd0, e.gnt});
                chk("sb_add",  {28'd0, bus.o_w_add},  {28'd0, e.add});
                chk("sb_data", {16'd0, bus.o_w_data}, {16'd0, e.data});
            end
        end
    end

    function automatic logic [31:0] outs();
        return {7'd0, bus.o_gnt, bus.o_w_en, bus.o_w_add, bus.o_w_data};
    endfunction

    initial begin
        in_rst          = 1'b1;
        bus.in_req      = '0;
        bus.in_req_add  = '0;
        bus.in_req_data = '0;
        bus.in_hold     = 1'b0;
        step();
        step();
        chk("reset_outs", outs(), 32'd0);
        chk("reset_cnt", {16'd0, bus.o_wr_cnt}, 32'd0);
        in_rst = 1'b0;

        // Single requester
        step();
        set_req(0, 4'h3, 16'hA5A5);
        push(4'b0001, 4'h3, 16'hA5A5);
        step();
        chk("single_gnt",  {28'd0, bus.o_gnt}, 32'h1);
        chk("single_w_en", {31'd0, bus.o_w_en}, 32'h1);
        chk("single_add",  {28'd0, bus.o_w_add}, 32'h3);
        chk("single_data", {16'd0, bus.o_w_data}, 32'hA5A5);
        chk("single_cnt",  {16'd0, bus.o_wr_cnt}, 32'd1);
        bus.in_req = '0;
        step();
        chk("single_w_en_drop", {31'd0, bus.o_w_en}, 32'h0);
        chk("single_rf3", {16'd0, rf_mem[3]}, 32'hA5A5);

        // Reset mid-grant, then idle
        set_req(1, 4'h5, 16'h5555);
        step();
        chk("midgrant_gnt", {28'd0, bus.o_gnt}, 32'h2);
        #1;
        in_rst     = 1'b1;
        bus.in_req = '0;
        #1;
        chk("async_rst_outs", outs(), 32'd0);
        chk("async_rst_cnt", {16'd0, bus.o_wr_cnt}, 32'd0);
        step();
        in_rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("idle_outs", outs(), 32'd0);
            chk("idle_cnt", {16'd0, bus.o_wr_cnt}, 32'd0);
        end

        // Round-robin fairness from ptr = 0
        for (int i = 0; i < 4; i++) begin
            set_req(i, 4'(i + 8), 16'h1000 + 16'(i));
            push(4'b0001 << i, 4'(i + 8), 16'h1000 + 16'(i));
        end
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr_gnt", {28'd0, bus.o_gnt}, 32'h1 << i);
            bus.in_req[i] = 1'b0;
        end
        chk("rr_cnt", {16'd0, bus.o_wr_cnt}, 32'd4);
        step();

        // Hold suppresses grants; release grants at ptr (0) first
        bus.in_hold = 1'b1;
        set_req(0, 4'h1, 16'hB000);
        set_req(1, 4'h2, 16'hB001);
        push(4'b0001, 4'h1, 16'hB000);
        push(4'b0010, 4'h2, 16'hB001);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("hold_w_en", {31'd0, bus.o_w_en}, 32'h0);
        end
        bus.in_hold = 1'b0;
        step();
        chk("hold_first_gnt", {28'd0, bus.o_gnt}, 32'h1);
        bus.in_req[0] = 1'b0;
        step();
        chk("hold_second_gnt", {28'd0, bus.o_gnt}, 32'h2);
        bus.in_req[1] = 1'b0;
        chk("hold_cnt", {16'd0, bus.o_wr_cnt}, 32'd6);

        // Back-to-back single requester: grant every other cycle
        set_req(2, 4'hC, 16'hC000);
        push(4'b0100, 4'hC, 16'hC000);
        for (int c = 0; c < 6; c++) begin
            step();
            chk("b2b_gnt", {28'd0, bus.o_gnt}, (c % 2 == 0) ? 32'h4 : 32'h0);
            if (c == 0 || c == 2) begin
                set_req(2, 4'hC, 16'hC000 + 16'(c + 1));
                push(4'b0100, 4'hC, 16'hC000 + 16'(c + 1));
            end else if (c == 4) begin
                bus.in_req[2] = 1'b0;
            end
        end
        chk("b2b_cnt", {16'd0, bus.o_wr_cnt}, 32'd9);

        // Same-address conflict with ptr back at 0
        in_rst = 1'b1;
        step();
        in_rst = 1'b0;
        set_req(0, 4'h7, 16'h1111);
        set_req(1, 4'h7, 16'h2222);
        push(4'b0001, 4'h7, 16'h1111);
        push(4'b0010, 4'h7, 16'h2222);
        step();
        chk("conf_gnt0", {28'd0, bus.o_gnt}, 32'h1);
        bus.in_req[0] = 1'b0;
        step();
        chk("conf_gnt1", {28'd0, bus.o_gnt}, 32'h2);
        bus.in_req[1] = 1'b0;
        step();
        chk("conf_rf7", {16'd0, rf_mem[7]}, 32'h2222);
        chk("conf_cnt", {16'd0, bus.o_wr_cnt}, 32'd2);

        step();
        step();
        chk("sb_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
